// File: rtl/uc_pkg.sv
// uc_pkg: opcode, ALU operation and FSM state definitions shared by the uc_seq control unit.
package uc_pkg;
  localparam logic [2:0] OP_LOAD    = 3'b000;
  localparam logic [2:0] OP_ADD     = 3'b001;
  localparam logic [2:0] OP_ADDI    = 3'b010;
  localparam logic [2:0] OP_SUB     = 3'b011;
  localparam logic [2:0] OP_SUBI    = 3'b100;
  localparam logic [2:0] OP_MUL     = 3'b101;
  localparam logic [2:0] OP_CLEAR   = 3'b110;
  localparam logic [2:0] OP_ILLEGAL = 3'b111;
  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b011;
  localparam logic [2:0] ALU_MUL  = 3'b101;
  localparam logic [2:0] ALU_CLR  = 3'b110;
  typedef enum logic [1:0] {ST_OFF, ST_IDLE, ST_EXEC, ST_WRITE} state_t;
  typedef struct packed {
    logic [2:0] alu_op;
    logic       alu_src;
  } ctl_t;
  function automatic ctl_t decode_op(input logic [2:0] op);
    ctl_t c;
    c.alu_op  = (op == OP_ADD || op == OP_ADDI) ? ALU_ADD :
                (op == OP_SUB || op == OP_SUBI) ? ALU_SUB :
                op == OP_MUL ? ALU_MUL : op == OP_CLEAR ? ALU_CLR : ALU_PASS;
    c.alu_src = op == OP_LOAD || op == OP_ADDI || op == OP_SUBI;
    return c;
  endfunction
endpackage

// File: rtl/uc_seq_botao_sync.sv
// botao_sync: 2-FF synchroniser, debounce counter and one-cycle press pulse for a bouncy button.
module botao_sync #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic pulse_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES);
  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d, pulse_q;
  // counter saturates once stable so a held button yields a single pulse
  always_comb begin
    cnt_d   = !sync_q[1] ? '0 : (cnt_q == CMAX ? cnt_q : cnt_q + 1'b1);
    level_d = cnt_d == CMAX;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= level_d & ~level_q;
    end
  end
  assign pulse_o = pulse_q;
endmodule

// File: rtl/uc_seq.sv
// uc_seq: sequential control unit capturing one switch-bank instruction per debounced press.
module uc_seq
  import uc_pkg::*;
#(
  parameter int DATA_W          = 16,
  parameter int REG_ADDR_W      = 4,
  parameter int IMM_W           = 7,
  parameter int MUL_LAT         = 3,
  parameter int DEBOUNCE_CYCLES = 250000,
  localparam int INSTR_W        = 3 + 2 * REG_ADDR_W + IMM_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ligar,
  input  logic                  enviar,
  input  logic [INSTR_W-1:0]    sw,
  output logic [REG_ADDR_W-1:0] dest,
  output logic [REG_ADDR_W-1:0] src1,
  output logic [REG_ADDR_W-1:0] src2,
  output logic [DATA_W-1:0]     imm_ext,
  output logic                  alu_src,
  output logic [2:0]            alu_op,
  output logic                  write_enable,
  output logic                  clear,
  output logic                  busy,
  output logic                  done,
  output logic                  illegal
);
  localparam int MW = $clog2(MUL_LAT + 1);
  localparam logic [MW-1:0] MUL_LAST = MW'(MUL_LAT - 1);
  logic [1:0]            ligar_q;
  logic                  accept, on, capture, exec_last;
  state_t                state_q, state_d;
  logic [MW-1:0]         cnt_q;
  logic [2:0]            op_q, sw_op, alu_op_q;
  logic                  alu_src_q;
  logic [REG_ADDR_W-1:0] dest_q, src1_q, src2_q;
  logic [IMM_W-1:0]      sw_imm;
  logic [DATA_W-1:0]     mag, imm_d, imm_q;
  ctl_t                  ctl;
  botao_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enviar (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_i  (enviar),
    .pulse_o(accept)
  );
  always_comb begin
    sw_op     = sw[INSTR_W-1 -: 3];
    sw_imm    = sw[IMM_W-1:0];
    mag       = DATA_W'(sw_imm[IMM_W-2:0]);
    imm_d     = sw_imm[IMM_W-1] ? -mag : mag;
    ctl       = decode_op(sw_op);
    on        = ligar_q[1];
    capture   = on && state_q == ST_IDLE && accept;
    exec_last = op_q != OP_MUL || cnt_q == MUL_LAST;
    // losing power overrides everything, including a same-cycle accept
    state_d   = !on ? ST_OFF :
                state_q == ST_OFF ? ST_IDLE :
                capture ? ST_EXEC :
                state_q == ST_EXEC ? (exec_last ? ST_WRITE : ST_EXEC) :
                state_q == ST_WRITE ? ST_IDLE : state_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ligar_q   <= '0;
      state_q   <= ST_OFF;
      cnt_q     <= '0;
      op_q      <= '0;
      alu_op_q  <= ALU_PASS;
      alu_src_q <= 1'b0;
      dest_q    <= '0;
      src1_q    <= '0;
      src2_q    <= '0;
      imm_q     <= '0;
    end else begin
      ligar_q <= {ligar_q[0], ligar};
      state_q <= state_d;
      cnt_q   <= capture ? '0 : state_q == ST_EXEC ? cnt_q + 1'b1 : cnt_q;
      if (capture) begin
        op_q      <= sw_op;
        alu_op_q  <= ctl.alu_op;
        alu_src_q <= ctl.alu_src;
        dest_q    <= sw[INSTR_W-4 -: REG_ADDR_W];
        src1_q    <= sw[IMM_W+REG_ADDR_W-1 -: REG_ADDR_W];
        src2_q    <= sw_imm[IMM_W-1 -: REG_ADDR_W];
        imm_q     <= imm_d;
      end
    end
  end
  assign dest         = dest_q;
  assign src1         = src1_q;
  assign src2         = src2_q;
  assign imm_ext      = imm_q;
  assign alu_src      = alu_src_q;
  assign alu_op       = alu_op_q;
  assign busy         = state_q == ST_EXEC || state_q == ST_WRITE;
  assign done         = state_q == ST_WRITE;
  assign write_enable = done && op_q != OP_ILLEGAL;
  assign clear        = done && op_q == OP_CLEAR;
  assign illegal      = done && op_q == OP_ILLEGAL;
endmodule

// File: tb/tb_uc_seq.sv
// tb_uc_seq: directed stimulus with a cycle-level reference model and hand-computed spot checks.
module tb_uc_seq;
  localparam int DB = 4;
  localparam int ML = 3;
  localparam int IW = 18;
  localparam int N  = 4096;
  logic clk = 1'b0, rst_n = 1'b0, ligar = 1'b1, enviar = 1'b0;
  logic [IW-1:0] sw = '0;
  logic [3:0]  dest, src1, src2;
  logic [15:0] imm_ext;
  logic        alu_src, write_enable, clear, busy, done, illegal;
  logic [2:0]  alu_op;
  int checks = 0, errors = 0;
  uc_seq #(.DATA_W(16), .REG_ADDR_W(4), .IMM_W(7), .MUL_LAT(ML), .DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .rst_n(rst_n), .ligar(ligar), .enviar(enviar), .sw(sw),
    .dest(dest), .src1(src1), .src2(src2), .imm_ext(imm_ext), .alu_src(alu_src),
    .alu_op(alu_op), .write_enable(write_enable), .clear(clear), .busy(busy),
    .done(done), .illegal(illegal)
  );
  always #5 clk = ~clk;

  // reference model: input samples per edge, plus the in-flight instruction and its start edge
  logic env_s [N];
  logic lig_s [N];
  logic [2:0] aop_tab [8] = '{3'd0, 3'd1, 3'd1, 3'd3, 3'd3, 3'd5, 3'd6, 3'd0};
  logic       asrc_tab [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  int cur = -1, m = 0;
  bit powered = 0, inflight = 0;
  logic [2:0]  mop = '0, e_aop = '0;
  logic [3:0]  e_dest = '0, e_src1 = '0, e_src2 = '0;
  logic [15:0] e_imm = '0;
  logic        e_asrc = 1'b0;
  int busy_rises = 0, we_count = 0, busy_run = 0, we_run = 0;
  bit prev_busy = 0;

  function automatic bit lig_at(int k);
    return k >= 0 && lig_s[k] === 1'b1;
  endfunction
  function automatic int run_end(int k);
    int r = 0;
    while (k >= 0 && r <= DB && env_s[k] === 1'b1) begin r++; k--; end
    return r;
  endfunction
  function automatic int lat(logic [2:0] op);
    return (op == 3'd5 ? ML : 1) + 1;
  endfunction

  task automatic model_step();
    int n, mag;
    bit lig_ok, acc;
    if (!rst_n) begin
      cur = -1; powered = 0; inflight = 0; mop = '0; e_aop = '0; e_asrc = 1'b0;
      e_dest = '0; e_src1 = '0; e_src2 = '0; e_imm = '0;
      return;
    end
    n = cur + 1;
    if (n < N) begin env_s[n] = enviar; lig_s[n] = ligar; end
    lig_ok = lig_at(n - 2);
    acc = run_end(n - 3) == DB;
    if (!lig_ok) begin
      powered = 0; inflight = 0;
    end else if (!powered) begin
      powered = 1;
    end else if (!(inflight && n - 1 - m < lat(mop)) && acc) begin
      inflight = 1; m = n; mop = sw[17:15];
      e_dest = sw[14:11]; e_src1 = sw[10:7]; e_src2 = sw[6:3];
      e_aop = aop_tab[mop]; e_asrc = asrc_tab[mop];
      mag = int'(sw[5:0]);
      e_imm = sw[6] ? 16'(-mag) : 16'(mag);
    end
    cur = n;
  endtask

  function automatic logic [63:0] exp_all();
    int k = cur - m;
    logic b, w;
    b = inflight && cur >= 0 && k < lat(mop);
    w = b && k == lat(mop) - 1;
    return 64'({e_dest, e_src1, e_src2, e_imm, e_asrc, e_aop,
                w && mop != 3'd7, w && mop == 3'd6, b, w, w && mop == 3'd7});
  endfunction
  function automatic logic [63:0] act_all();
    return 64'({dest, src1, src2, imm_ext, alu_src, alu_op, write_enable, clear, busy, done, illegal});
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    model_step();
  end

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("model", act_all(), exp_all());
      busy_run = busy ? busy_run + 1 : 0;
      if (busy && !prev_busy) busy_rises++;
      if (write_enable) begin we_count++; we_run = busy_run; end
      prev_busy = busy;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic press(input int hold);
    enviar = 1'b1; tick(hold); enviar = 1'b0;
  endtask
  task automatic wait_busy(input string name);
    int t = 0;
    while (busy !== 1'b1 && t < 60) begin tick(1); t++; end
    chk(name, 64'(busy), 64'd1);
  endtask

  initial begin
    int r0, w0;
    tick(3);
    chk("reset", act_all(), 64'd0);
    rst_n = 1'b1; tick(4);
    // ADDI r2, r1, -5
    sw = 18'b010_0010_0001_1000101;
    press(6); wait_busy("addi_start");
    chk("addi_dec", 64'({dest, src1, src2, imm_ext, alu_src, alu_op}),
        64'({4'd2, 4'd1, 4'd8, 16'hFFFB, 1'b1, 3'b001}));
    chk("addi_t1_we", 64'(write_enable), 64'd0);
    tick(1); chk("addi_t2", 64'({write_enable, done, busy}), 64'b111);
    tick(1); chk("addi_t3", 64'({write_enable, busy}), 64'd0);
    sw = '1; tick(2); chk("addi_hold", 64'(dest), 64'd2);
    // MUL with the button held well past the accept
    sw = 18'b101_0011_0001_0010000;
    r0 = busy_rises; w0 = we_count;
    press(14); tick(6);
    chk("mul_one_accept", 64'(busy_rises - r0), 64'd1);
    chk("mul_one_we", 64'(we_count - w0), 64'd1);
    chk("mul_we_at_t4", 64'(we_run), 64'd4);
    chk("mul_aop", 64'({alu_op, alu_src, src2}), 64'({3'b101, 1'b0, 4'd2}));
    // bouncy press: high 2, low 1, high 10
    sw = 18'b001_0100_0101_0000011;
    r0 = busy_rises;
    enviar = 1'b1; tick(2); enviar = 1'b0; tick(1); press(10); tick(6);
    chk("bounce_one_accept", 64'(busy_rises - r0), 64'd1);
    // CLEAR
    sw = 18'b110_0000_0000_0000000;
    press(6); wait_busy("clr_start");
    tick(1); chk("clr_pulse", 64'({clear, write_enable, done}), 64'b111);
    tick(1); chk("clr_end", 64'({clear, write_enable, done}), 64'd0);
    // illegal opcode with negative zero immediate
    sw = 18'b111_0001_0010_1000000;
    press(6); wait_busy("ill_start");
    chk("ill_dec", 64'({imm_ext, alu_op, alu_src, src2}), 64'({16'd0, 3'd0, 1'b0, 4'd8}));
    tick(1); chk("ill_pulse", 64'({illegal, done, write_enable}), 64'b110);
    tick(2);
    // power lost mid-MUL aborts without a write
    sw = 18'b101_0011_0001_0010000;
    press(6); wait_busy("abort_start");
    ligar = 1'b0; w0 = we_count;
    tick(8);
    chk("abort_no_we", 64'(we_count - w0), 64'd0);
    chk("abort_idle", 64'(busy), 64'd0);
    // power back; a press whose accept coincides with power loss is dropped
    ligar = 1'b1; tick(4);
    r0 = busy_rises;
    enviar = 1'b1; tick(4); ligar = 1'b0; tick(2); enviar = 1'b0; tick(4);
    chk("off_wins", 64'(busy_rises - r0), 64'd0);
    ligar = 1'b1; tick(4);
    sw = 18'b001_0100_0101_0000011; w0 = we_count;
    press(6); wait_busy("after_power");
    tick(3); chk("after_power_we", 64'(we_count - w0), 64'd1);
    // asynchronous reset in EXEC
    sw = 18'b101_0011_0001_0010000;
    press(6); wait_busy("rst_start");
    #2 rst_n = 1'b0;
    #1 chk("async_rst", act_all(), 64'd0);
    tick(2); rst_n = 1'b1; tick(4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uc_seq.md
# uc_seq

Parametrised, sequential successor to the Mini-CPU control unit. It synchronises and debounces the `enviar` button and captures one instruction per accepted press from the switch bank. It decodes the instruction into register addresses, a sign-magnitude immediate and ALU controls. It then sequences execution through a small FSM, with a multi-cycle MUL and a single-cycle register-file write strobe. It sits between the board switches/buttons and the register file/ALU datapath.

## Interface
- `DATA_W`, 16: datapath width; width of `imm_ext`.
- `REG_ADDR_W`, 4: register address width.
- `IMM_W`, 7: immediate field width; MSB is the sign, the rest is the magnitude. Must satisfy `IMM_W >= REG_ADDR_W` and `IMM_W <= DATA_W`.
- `MUL_LAT`, 3: EXEC cycles for MUL, at least 1.
- `DEBOUNCE_CYCLES`, 250000: cycles of stable high required to accept a press.
- `INSTR_W`, localparam: equals 3 + 2·`REG_ADDR_W` + `IMM_W` (18 at defaults).

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `ligar` in 1: power enable; asynchronous switch.
- `enviar` in 1: send button; active-high; asynchronous and bouncy.
- `sw` in `INSTR_W`: instruction bits `{opcode, dest, src1, imm}`, MSB first.
- `dest`, `src1`, `src2` out `REG_ADDR_W` each: register addresses from the captured instruction. `src2` is the top `REG_ADDR_W` bits of the imm field.
- `imm_ext` out `DATA_W`: signed immediate.
- `alu_src` out 1: 1 selects `imm_ext`.
- `alu_op` out 3: ALU operation.
- `write_enable` out 1: register-file write strobe.
- `clear` out 1: clear strobe.
- `busy` out 1: an instruction is in flight.
- `done` out 1: one-cycle completion pulse.
- `illegal` out 1: one-cycle pulse for opcode 111.

## Operation
- `ligar` and `enviar` each pass through a 2-FF synchroniser.
- Debounce: the debounced level rises only after `DEBOUNCE_CYCLES` consecutive synchronised-high cycles. It falls on the first low cycle. The rising edge of the debounced level produces a one-cycle `accept` pulse.
- FSM states:
  - OFF → IDLE when synchronised `ligar`=1.
  - IDLE → EXEC on `accept`; `sw` is latched into the instruction register in the same edge.
  - EXEC → WRITE after 1 cycle, or after `MUL_LAT` cycles for MUL.
  - WRITE → IDLE.
  - From any state, synchronised `ligar`=0 forces OFF on the next edge.
- Decode is from the latched register only; `sw` changes after capture have no effect.
- Opcode decode gives `alu_op`, `alu_src` and `write_enable`-in-WRITE:
  - 000 LOAD: 000, 1, 1.
  - 001 ADD: 001, 0, 1.
  - 010 ADDI: 001, 1, 1.
  - 011 SUB: 011, 0, 1.
  - 100 SUBI: 011, 1, 1.
  - 101 MUL: 101, 0, 1.
  - 110 CLEAR: 110, 0, 1, with `clear`=1 in WRITE.
  - 111 illegal: 000, 0, 0, with `illegal`=1 in WRITE.
- Immediate: magnitude is zero-extended to `DATA_W`. If the sign bit is set, `imm_ext` is the two's-complement negation of that value. Negative zero gives 0.
- `alu_op`, `alu_src`, `imm_ext` and address outputs are registered. They hold from EXEC entry until the next capture, so IDLE keeps the last instruction.

## Timing
- Reset: state OFF, instruction register 0, debounce counter 0. All outputs are 0, including `imm_ext`=0 and `alu_op`=000.
- With `accept` at cycle T:
  - Decoded outputs are valid from T+1.
  - Non-MUL: WRITE at T+2; `write_enable`, `clear`, `done` and `illegal` are high in that cycle only; IDLE at T+3.
  - MUL: WRITE at T+1+`MUL_LAT`.
- `busy`=1 from T+1 through the WRITE cycle inclusive.
- Press-to-`accept` latency is 2 synchroniser cycles + `DEBOUNCE_CYCLES` + 1.
- `accept` outside IDLE is discarded, not queued.
- Holding the button produces exactly one `accept`; a new press needs release then stable high again.
- `ligar` falling mid-instruction aborts: no `write_enable` pulse occurs for that instruction, and `busy`=0 from the OFF cycle.
- `ligar`=0 and `accept` in the same cycle: OFF wins; nothing is captured.
- Asynchronous reset mid-instruction immediately clears all outputs.

## Structure
- Package `uc_pkg` holds:
  - opcode constants (`OP_LOAD`…`OP_ILLEGAL`);
  - ALU op constants (`ALU_PASS`=000, `ALU_ADD`=001, `ALU_SUB`=011, `ALU_MUL`=101, `ALU_CLR`=110);
  - the FSM state enum.
- Sub-module `botao_sync`: synchroniser, debounce counter and rising-edge pulse, parametrised by `DEBOUNCE_CYCLES`. It is instantiated for `enviar`; `ligar` uses its synchroniser only.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and `MUL_LAT`=3.
- Reset with `ligar`=1, then ADDI with `sw`=010_0010_0001_1000101: `dest`=2, `src1`=1, `imm_ext`=16'hFFFB, `alu_src`=1, `alu_op`=001. `write_enable` is high exactly at T+2.
- MUL `sw`=101_0011_0001_0010_000: `busy` is high for 4 cycles and `write_enable` is at T+4. A second press at T+2 produces no extra `accept`.
- Bouncy `enviar` (high 2 cycles, low 1, high 10): exactly one `accept`, which occurs after the stable stretch.
- CLEAR (110) gives `clear`=`write_enable`=`done`=1 for one cycle. Opcode 111 gives `illegal`=`done`=1 and `write_enable`=0. Immediate 1000000 gives `imm_ext`=0.
- `ligar` dropped at T+2 of a MUL: no `write_enable`, and state is OFF. After `ligar` returns, the next press executes normally.
- Assert `rst_n`=0 mid-EXEC: all outputs are 0 asynchronously.
